// File: rtl/nabp_filtered_ram_ring_control.sv
// Ring controller for NUM_BUFS filtered-RAM swappables: the host fills buffers in
// ring order while the processing array works them in the same order.
module nabp_filtered_ram_ring_control #(
    parameter int NUM_BUFS = 4,
    parameter int ANGLE_W  = 8,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ANGLE_W-1:0]  hs_angle,
    input  logic                hs_has_next_angle,
    output logic                hs_next_angle,
    input  logic                hs_next_angle_ack,
    input  logic                pr_next_angle,
    output logic                pr_next_angle_ack,
    output logic [ANGLE_W-1:0]  pr_angle,
    output logic                pr_has_next_angle,
    output logic [NUM_BUFS-1:0] buf_fill_kick,
    input  logic [NUM_BUFS-1:0] buf_fill_done,
    output logic [SEL_W-1:0]    fill_sel,
    output logic [SEL_W-1:0]    work_sel,
    output logic [SEL_W:0]      ready_count
);

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_DRAIN = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_WORKING = 2'd3
    } buf_state_t;

    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1'b1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_BUFS - 1);
    localparam logic [SEL_W:0]   READY_MAX = (SEL_W + 1)'(NUM_BUFS - 1);

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        return (p == SEL_LAST) ? {SEL_W{1'b0}} : (p + SEL_ONE);
    endfunction

    ctrl_state_t          ctrl_q, ctrl_d;
    buf_state_t           buf_q [NUM_BUFS];
    buf_state_t           buf_d [NUM_BUFS];
    logic [ANGLE_W-1:0]   angle_q [NUM_BUFS];
    logic [ANGLE_W-1:0]   angle_d [NUM_BUFS];
    logic [NUM_BUFS-1:0]  last_q, last_d;
    logic [SEL_W-1:0]     fp_q, fp_d, wp_q, wp_d;
    logic [SEL_W-1:0]     fill_sel_q, fill_sel_d, work_sel_q, work_sel_d;
    logic [ANGLE_W-1:0]   pr_angle_q, pr_angle_d;
    logic                 pr_has_next_q, pr_has_next_d;
    logic [NUM_BUFS-1:0]  kick_q, kick_d;
    logic [SEL_W:0]       ready_count_q, ready_count_d;

    logic any_filling_s;
    logic work_avail_s;
    logic drain_release_s;
    logic hs_req_s;
    logic host_ack_s;
    logic pr_ack_s;

    // Status decode for both handshakes
    always_comb begin
        any_filling_s = 1'b0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            any_filling_s = any_filling_s | (buf_q[i] == BUF_FILLING);
        end
        work_avail_s    = (buf_q[wp_q] == BUF_FULL);
        // Release of the final angle: nothing left to hand over, last buffer in work.
        drain_release_s = (ctrl_q == CTRL_DRAIN) && !work_avail_s &&
                          (buf_q[work_sel_q] == BUF_WORKING) && !pr_has_next_q;
        hs_req_s = 1'b0;
        if (reset_n) begin
            case (ctrl_q)
                CTRL_IDLE: hs_req_s = 1'b1;
                CTRL_RUN:  hs_req_s = (buf_q[fp_q] == BUF_FREE) && !any_filling_s &&
                                      (ready_count_q < READY_MAX);
                default:   hs_req_s = 1'b0;
            endcase
        end else begin
            hs_req_s = 1'b0;
        end
        host_ack_s = hs_next_angle_ack && hs_req_s;
        pr_ack_s   = reset_n && pr_next_angle && (work_avail_s || drain_release_s);
    end

    // Next-state for the controller FSM, buffer ring and output registers
    always_comb begin
        ctrl_d        = ctrl_q;
        last_d        = last_q;
        fp_d          = fp_q;
        wp_d          = wp_q;
        fill_sel_d    = fill_sel_q;
        work_sel_d    = work_sel_q;
        pr_angle_d    = pr_angle_q;
        pr_has_next_d = pr_has_next_q;
        kick_d        = {NUM_BUFS{1'b0}};
        ready_count_d = {(SEL_W + 1){1'b0}};
        for (int i = 0; i < NUM_BUFS; i++) begin
            angle_d[i] = angle_q[i];
            buf_d[i]   = (buf_fill_done[i] && (buf_q[i] == BUF_FILLING)) ? BUF_FULL : buf_q[i];
        end

        // Only one fill is ever in flight and it always sits at fp.
        if (buf_fill_done[fp_q] && (buf_q[fp_q] == BUF_FILLING)) begin
            fp_d = next_ptr(fp_q);
        end else begin
            fp_d = fp_q;
        end

        if (host_ack_s) begin
            buf_d[fp_q]   = BUF_FILLING;
            angle_d[fp_q] = hs_angle;
            last_d[fp_q]  = ~hs_has_next_angle;
            fill_sel_d    = fp_q;
            kick_d[fp_q]  = 1'b1;
            ctrl_d        = hs_has_next_angle ? CTRL_RUN : CTRL_DRAIN;
        end else begin
            kick_d = {NUM_BUFS{1'b0}};
        end

        if (pr_ack_s) begin
            if (buf_q[work_sel_q] == BUF_WORKING) begin
                buf_d[work_sel_q] = BUF_FREE;
            end else begin
                buf_d[work_sel_q] = buf_d[work_sel_q];
            end
            if (work_avail_s) begin
                buf_d[wp_q]   = BUF_WORKING;
                work_sel_d    = wp_q;
                pr_angle_d    = angle_q[wp_q];
                pr_has_next_d = ~last_q[wp_q];
                wp_d          = next_ptr(wp_q);
            end else begin
                ctrl_d = CTRL_IDLE;
            end
        end else begin
            wp_d = wp_q;
        end

        for (int i = 0; i < NUM_BUFS; i++) begin
            ready_count_d = ready_count_d + {{SEL_W{1'b0}}, (buf_d[i] == BUF_FULL)};
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q        <= CTRL_IDLE;
            last_q        <= {NUM_BUFS{1'b0}};
            fp_q          <= {SEL_W{1'b0}};
            wp_q          <= {SEL_W{1'b0}};
            fill_sel_q    <= {SEL_W{1'b0}};
            work_sel_q    <= {SEL_W{1'b0}};
            pr_angle_q    <= {ANGLE_W{1'b0}};
            pr_has_next_q <= 1'b0;
            kick_q        <= {NUM_BUFS{1'b0}};
            ready_count_q <= {(SEL_W + 1){1'b0}};
            for (int i = 0; i < NUM_BUFS; i++) begin
                buf_q[i]   <= BUF_FREE;
                angle_q[i] <= {ANGLE_W{1'b0}};
            end
        end else begin
            ctrl_q        <= ctrl_d;
            last_q        <= last_d;
            fp_q          <= fp_d;
            wp_q          <= wp_d;
            fill_sel_q    <= fill_sel_d;
            work_sel_q    <= work_sel_d;
            pr_angle_q    <= pr_angle_d;
            pr_has_next_q <= pr_has_next_d;
            kick_q        <= kick_d;
            ready_count_q <= ready_count_d;
            for (int i = 0; i < NUM_BUFS; i++) begin
                buf_q[i]   <= buf_d[i];
                angle_q[i] <= angle_d[i];
            end
        end
    end

    assign hs_next_angle     = hs_req_s;
    assign pr_next_angle_ack = pr_ack_s;
    assign pr_angle          = pr_angle_q;
    assign pr_has_next_angle = pr_has_next_q;
    assign buf_fill_kick     = kick_q;
    assign fill_sel          = fill_sel_q;
    assign work_sel          = work_sel_q;
    assign ready_count       = ready_count_q;

endmodule
